muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the SimpleRV core, sitting beside the combinational `alu` in the execute stage. It accepts one operation per request, computes it over multiple cycles with a shift-add multiplier and a restoring divider, and returns the 32-bit result on a valid/ready response channel. The pipeline stalls on `req_ready`/`resp_valid`.

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Shift-add multiplier and restoring divider, one bit per cycle, sharing a
//   single {hi, lo} working register pair. Signed operands are reduced to
//   magnitudes at accept; the result sign is applied when leaving BUSY.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake; op (funct3), a (rs1), b (rs2)
//   resp_valid/ready  - response handshake; y held stable while resp_valid
module muldiv_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] y
);
  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0]     LAST    = CW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]        op_r;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] hi, lo, m;   // mul: lo=multiplier, m=multiplicand; div: lo=dividend/quotient, hi=remainder, m=divisor
  logic              neg;

  // ---- accept-time decode ----
  logic              a_sgn, b_sgn, sa, sb, div_zero, div_ovf, special, neg_in;
  logic [DWIDTH-1:0] a_mag, b_mag, special_y;

  always_comb begin
    a_sgn     = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    b_sgn     = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    sa        = a_sgn & a[DWIDTH-1];
    sb        = b_sgn & b[DWIDTH-1];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;
    // REM/REMU (op 11x) take the dividend sign; everything else sign(a)^sign(b)
    neg_in    = (op[2] & op[1]) ? sa : (sa ^ sb);
    div_zero  = op[2] & (b == '0);
    div_ovf   = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
    special   = div_zero | div_ovf;
    // op[1] selects remainder among the divide ops
    if (div_zero) special_y = op[1] ? a : '1;
    else          special_y = op[1] ? '0 : a;
  end

  // ---- one iteration ----
  logic [DWIDTH:0]     sum, shifted, diff;
  logic                ge;
  logic [DWIDTH-1:0]   step_hi, step_lo, quo, rem, result;
  logic [2*DWIDTH-1:0] prod;

  always_comb begin
    // multiply: conditionally add, then shift {carry, hi, lo} right by one
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    // divide: shift next dividend bit into remainder, trial-subtract divisor
    shifted = {hi, lo[DWIDTH-1]};
    diff    = shifted - {1'b0, m};
    ge      = ~diff[DWIDTH];
    if (op_r[2]) begin
      step_hi = ge ? diff[DWIDTH-1:0] : shifted[DWIDTH-1:0];
      step_lo = {lo[DWIDTH-2:0], ge};
    end else begin
      step_hi = sum[DWIDTH:1];
      step_lo = {sum[0], lo[DWIDTH-1:1]};
    end
    prod = {step_hi, step_lo};
    if (neg) prod = -prod;
    quo  = neg ? -step_lo : step_lo;
    rem  = neg ? -step_hi : step_hi;
    case (op_r)
      3'b000:                 result = prod[DWIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*DWIDTH-1:DWIDTH];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  // ---- FSM ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = special ? DONE : BUSY;
      BUSY: if (cnt == LAST) state_nx = DONE;
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= '0;
      op_r  <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            op_r <= op;
            neg  <= neg_in;
            hi   <= '0;
            lo   <= op[2] ? a_mag : b_mag;
            m    <= op[2] ? b_mag : a_mag;
            if (special) y <= special_y;
          end
        end
        BUSY: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) y <= result;
        end
        default: ;
      endcase
    end
  end
endmodule
